// File: rtl/bet_sender.sv
// Queues 5-digit BCD bets from a host and replays each as the num/insere/fim/fim_jogo
// entry sequence for the lottery core, then returns the core's prize code.
module bet_sender #(
  parameter int DIGITS = 5,
  parameter int DEPTH  = 4,
  parameter int GAP    = 1
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [4*DIGITS-1:0]      bet_in,
  input  logic                     bet_valid,
  output logic                     bet_ready,
  output logic [3:0]               num,
  output logic                     insere,
  output logic                     fim,
  output logic                     fim_jogo,
  input  logic [1:0]               premio_in,
  output logic [1:0]               result,
  output logic                     result_valid,
  output logic                     err,
  output logic                     busy,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int BW   = 4 * DIGITS;
  localparam int PW   = $clog2(DEPTH);
  localparam int CNTW = PW + 1;
  localparam int MAXC = (DIGITS > GAP) ? DIGITS : GAP;
  localparam int CW   = $clog2(MAXC + 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_SEND,
    S_GAP,
    S_FIM,
    S_FJOG,
    S_SETTLE
  } state_t;

  state_t          state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [BW-1:0]   shift_q, shift_d;
  logic [PW-1:0]   wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]   rd_ptr_q, rd_ptr_d;
  logic [CNTW-1:0] count_q, count_d;
  logic [3:0]      num_q, num_d;
  logic            insere_q, insere_d;
  logic            fim_q, fim_d;
  logic            fim_jogo_q, fim_jogo_d;
  logic [1:0]      result_q, result_d;
  logic            result_valid_q, result_valid_d;
  logic            err_q, err_d;
  logic            busy_q, busy_d;

  logic [BW-1:0]     fifo_mem [DEPTH];
  logic [DIGITS-1:0] nib_bad;
  logic              bad_bcd;
  logic              accept;
  logic              push;
  logic              pop;

  generate
    for (genvar gi = 0; gi < DIGITS; gi++) begin : g_bcd
      assign nib_bad[gi] = (bet_in[4*gi +: 4] > 4'd9);
    end
  endgenerate

  assign bad_bcd   = |nib_bad;
  // Readiness depends only on the registered count, so a same-edge dequeue never opens a full FIFO.
  assign bet_ready = (count_q < CNTW'(DEPTH));
  assign accept    = bet_valid && bet_ready;
  assign push      = accept && !bad_bcd;
  assign pop       = (state_q == S_IDLE) && (count_q != '0);

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    shift_d  = shift_q;
    result_d = result_q;
    case (state_q)
      S_IDLE: begin
        if (count_q != '0) begin
          shift_d = fifo_mem[rd_ptr_q];
          cnt_d   = '0;
          state_d = S_SEND;
        end
      end
      S_SEND: begin
        shift_d = shift_q << 4;
        if (cnt_q == CW'(DIGITS - 1)) begin
          cnt_d   = '0;
          state_d = S_GAP;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      S_GAP: begin
        if (cnt_q == CW'(GAP - 1)) begin
          cnt_d   = '0;
          state_d = S_FIM;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      S_FIM:    state_d = S_FJOG;
      S_FJOG: begin
        result_d = premio_in;
        state_d  = S_SETTLE;
      end
      S_SETTLE: state_d = S_IDLE;
      default:  state_d = S_IDLE;
    endcase

    // Core-facing strobes are decoded from the next state and registered.
    num_d          = (state_d == S_SEND) ? shift_d[BW-1 -: 4] : 4'd0;
    insere_d       = (state_d == S_SEND);
    fim_d          = (state_d == S_FIM);
    fim_jogo_d     = (state_d == S_FJOG);
    result_valid_d = (state_d == S_SETTLE);
    busy_d         = (state_d != S_IDLE);
    err_d          = accept && bad_bcd;
  end

  always_comb begin
    wr_ptr_d = push ? (wr_ptr_q + PW'(1)) : wr_ptr_q;
    rd_ptr_d = pop  ? (rd_ptr_q + PW'(1)) : rd_ptr_q;
    count_d  = count_q;
    case ({push, pop})
      2'b10:   count_d = count_q + CNTW'(1);
      2'b01:   count_d = count_q - CNTW'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset && push) begin
      fifo_mem[wr_ptr_q] <= bet_in;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q        <= S_IDLE;
      cnt_q          <= '0;
      shift_q        <= '0;
      wr_ptr_q       <= '0;
      rd_ptr_q       <= '0;
      count_q        <= '0;
      num_q          <= '0;
      insere_q       <= 1'b0;
      fim_q          <= 1'b0;
      fim_jogo_q     <= 1'b0;
      result_q       <= '0;
      result_valid_q <= 1'b0;
      err_q          <= 1'b0;
      busy_q         <= 1'b0;
    end else begin
      state_q        <= state_d;
      cnt_q          <= cnt_d;
      shift_q        <= shift_d;
      wr_ptr_q       <= wr_ptr_d;
      rd_ptr_q       <= rd_ptr_d;
      count_q        <= count_d;
      num_q          <= num_d;
      insere_q       <= insere_d;
      fim_q          <= fim_d;
      fim_jogo_q     <= fim_jogo_d;
      result_q       <= result_d;
      result_valid_q <= result_valid_d;
      err_q          <= err_d;
      busy_q         <= busy_d;
    end
  end

  assign num          = num_q;
  assign insere       = insere_q;
  assign fim          = fim_q;
  assign fim_jogo     = fim_jogo_q;
  assign result       = result_q;
  assign result_valid = result_valid_q;
  assign err          = err_q;
  assign busy         = busy_q;
  assign count        = count_q;

endmodule

// File: tb/tb_bet_sender.sv
// Directed bench for bet_sender: a negedge monitor scores digits and prizes against
// queues filled as bets and prize codes are driven.
module tb_bet_sender;

  localparam int DIGITS = 5;
  localparam int DEPTH  = 4;
  localparam int GAP    = 1;
  localparam int BW     = 4 * DIGITS;

  logic                    clk;
  logic                    reset;
  logic [BW-1:0]           bet_in;
  logic                    bet_valid;
  logic                    bet_ready;
  logic [3:0]              num;
  logic                    insere;
  logic                    fim;
  logic                    fim_jogo;
  logic [1:0]              premio_in;
  logic [1:0]              result;
  logic                    result_valid;
  logic                    err;
  logic                    busy;
  logic [$clog2(DEPTH):0]  count;

  bet_sender #(.DIGITS(DIGITS), .DEPTH(DEPTH), .GAP(GAP)) dut (
    .clk(clk), .reset(reset), .bet_in(bet_in), .bet_valid(bet_valid),
    .bet_ready(bet_ready), .num(num), .insere(insere), .fim(fim),
    .fim_jogo(fim_jogo), .premio_in(premio_in), .result(result),
    .result_valid(result_valid), .err(err), .busy(busy), .count(count)
  );

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  logic [3:0] dig_q[$];
  logic [1:0] premio_q[$];
  logic [1:0] res_q[$];
  int         rise_cyc[$];
  int         rv_cyc[$];
  int         fim_cnt = 0;
  int         rv_cnt = 0;
  int         peak = 0;
  bit         mon_en = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic bit bcd_ok(input logic [BW-1:0] b);
    for (int i = 0; i < DIGITS; i++) if (b[4*i +: 4] > 4'd9) return 1'b0;
    return 1'b1;
  endfunction

  task automatic send_bet(input logic [BW-1:0] b, output int waited);
    bet_in    = b;
    bet_valid = 1'b1;
    waited    = 0;
    while (!bet_ready && waited < 100) begin
      tick();
      waited++;
    end
    if (waited >= 100) chk("ready_timeout", {31'd0, bet_ready}, 32'd1);
    if (bcd_ok(b)) for (int i = 0; i < DIGITS; i++) dig_q.push_back(b[BW-1-4*i -: 4]);
    tick();
    bet_valid = 1'b0;
  endtask

  task automatic wait_drain();
    int n = 0;
    while ((dig_q.size() != 0 || res_q.size() != 0 || busy || count != 0) && n < 400) begin
      tick();
      n++;
    end
    chk("drain_busy", {31'd0, busy}, 32'd0);
    chk("drain_count", count, 32'd0);
  endtask

  task automatic chk_reset_vals();
    chk("rst_num", num, 0);
    chk("rst_insere", insere, 0);
    chk("rst_fim", fim, 0);
    chk("rst_fim_jogo", fim_jogo, 0);
    chk("rst_result", result, 0);
    chk("rst_result_valid", result_valid, 0);
    chk("rst_err", err, 0);
    chk("rst_busy", busy, 0);
    chk("rst_count", count, 0);
    chk("rst_bet_ready", bet_ready, 1);
  endtask

  // Monitor: scores each insere digit, the fim/fim_jogo spacing, and drives premio_in in FJOG.
  initial begin
    bit   prev_ins = 0;
    int   ins_run = 0, last_run = 0, last_ins_cyc = 0, fim_cyc = 0, fjog_cyc = 0;
    logic [1:0] p;
    premio_in = 2'd0;
    forever begin
      @(negedge clk);
      if (mon_en) begin
        if (count > peak) peak = count;
        if (insere === 1'b1) begin
          if (!prev_ins) rise_cyc.push_back(cyc);
          ins_run++;
          if (dig_q.size() == 0) chk("insere_without_bet", {31'd0, insere}, 32'd0);
          else chk("num", num, dig_q.pop_front());
        end else begin
          if (prev_ins) begin
            last_run     = ins_run;
            last_ins_cyc = cyc - 1;
            ins_run      = 0;
          end
          chk("num_idle", num, 0);
        end
        prev_ins = (insere === 1'b1);
        if (fim === 1'b1) begin
          fim_cnt++;
          chk("fim_gap", cyc - last_ins_cyc, GAP + 1);
          chk("insere_run", last_run, DIGITS);
          fim_cyc = cyc;
        end
        if (fim_jogo === 1'b1) begin
          chk("fjog_after_fim", cyc - fim_cyc, 1);
          fjog_cyc  = cyc;
          p         = (premio_q.size() != 0) ? premio_q.pop_front() : 2'd0;
          premio_in = p;
          res_q.push_back(p);
        end
        if (result_valid === 1'b1) begin
          rv_cnt++;
          rv_cyc.push_back(cyc);
          chk("rv_after_fjog", cyc - fjog_cyc, 1);
          if (res_q.size() == 0) chk("rv_without_fjog", {31'd0, result_valid}, 32'd0);
          else chk("result", result, res_q.pop_front());
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL global_timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

  initial begin
    int w, t0, rises, f0, r0;
    logic [BW-1:0] five [5];
    reset     = 1'b0;
    bet_valid = 1'b0;
    bet_in    = '0;
    repeat (3) tick();
    chk_reset_vals();
    reset  = 1'b1;
    tick();
    mon_en = 1;

    // Single bet, then three more queued behind it while it is being sent.
    premio_q.push_back(2'd1);
    premio_q.push_back(2'd2);
    premio_q.push_back(2'd1);
    premio_q.push_back(2'd0);
    peak = 0;
    send_bet(20'h47010, w);
    t0 = cyc;
    chk("t1_count", count, 1);
    chk("t1_busy_idle", busy, 0);
    chk("t1_insere_idle", insere, 0);
    tick();
    chk("t1_busy", busy, 1);
    chk("t1_insere", insere, 1);
    chk("t1_num0", num, 4);
    chk("t1_count0", count, 0);
    send_bet(20'h67039, w);
    send_bet(20'h47029, w);
    send_bet(20'h23119, w);
    chk("t2_count3", count, 3);
    chk("t2_ready", bet_ready, 1);
    wait_drain();
    chk("t2_peak", peak, 3);
    chk("t2_rises", rise_cyc.size(), 4);
    for (int i = 1; i < rise_cyc.size(); i++) chk("t2_spacing", rise_cyc[i] - rise_cyc[i-1], DIGITS + GAP + 4);
    chk("t2_rv_count", rv_cyc.size(), 4);
    if (rv_cyc.size() != 0) chk("t1_rv_latency", rv_cyc[0] - t0, DIGITS + GAP + 3);

    // FIFO fill: one bet in flight, five offered back to back, the fifth stalls.
    five[0] = 20'h98765; five[1] = 20'h00000; five[2] = 20'h99999;
    five[3] = 20'h50505; five[4] = 20'h31415;
    for (int i = 0; i < 6; i++) premio_q.push_back(2'($urandom_range(0, 3)));
    send_bet(20'h12345, w);
    tick();
    for (int i = 0; i < 4; i++) send_bet(five[i], w);
    chk("t3_count_full", count, 4);
    chk("t3_ready_full", bet_ready, 0);
    send_bet(five[4], w);
    chk("t3_stall_cycles", w, 6);
    chk("t3_count_after", count, 4);
    wait_drain();

    // Non-BCD bet is dropped with an err pulse; the next bet goes through.
    premio_q.push_back(2'd2);
    rises = rise_cyc.size();
    send_bet(20'h4A019, w);
    chk("t4_err", err, 1);
    chk("t4_count", count, 0);
    chk("t4_busy", busy, 0);
    tick();
    chk("t4_err_once", err, 0);
    chk("t4_no_insere", insere, 0);
    send_bet(20'h17011, w);
    chk("t4_err_clean", err, 0);
    chk("t4_count_good", count, 1);
    wait_drain();
    chk("t4_rises", rise_cyc.size(), rises + 1);

    // Reset during the third SEND cycle with two bets still queued.
    send_bet(20'h35792, w);
    send_bet(20'h24680, w);
    send_bet(20'h13579, w);
    chk("t5_count2", count, 2);
    tick();
    chk("t5_insere", insere, 1);
    chk("t5_num2", num, 7);
    reset     = 1'b0;
    bet_valid = 1'b1;
    bet_in    = 20'h55555;
    tick();
    chk_reset_vals();
    dig_q.delete();
    res_q.delete();
    premio_q.delete();
    reset     = 1'b1;
    bet_valid = 1'b0;
    f0    = fim_cnt;
    r0    = rv_cnt;
    rises = rise_cyc.size();
    repeat (20) tick();
    chk("t5_no_fim", fim_cnt, f0);
    chk("t5_no_rv", rv_cnt, r0);
    chk("t5_no_insere", rise_cyc.size(), rises);
    chk("t5_count_after", count, 0);
    chk("t5_busy_after", busy, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/bet_sender.md
# bet_sender

Transmit side of the lottery digit-entry interface. The block queues 5-digit BCD bets from a host and replays each bet as the cycle-exact `num`/`insere`/`fim`/`fim_jogo` sequence that the lottery core consumes. It then captures the core's prize code for that bet and returns it to the host. It sits between a host (keypad scanner, UART bridge or bench driver) and the lottery core, replacing hand-driven entry.

## Interface
- `DIGITS`, 5, number of BCD digits per bet.
- `DEPTH`, 4, bet FIFO depth (power of two, ≥2).
- `GAP`, 1, low cycles between the last `insere` cycle and the `fim` pulse (≥1).

- `clk`  in  1  single clock, all logic on rising edge.
- `reset`  in  1  synchronous, active-low; 0 on a rising edge clears all state.
- `bet_in`  in  4*DIGITS  bet, BCD; digit 0 (sent first) in the top nibble.
- `bet_valid`  in  1  host offers `bet_in`.
- `bet_ready`  out  1  FIFO can accept; transfer when `bet_valid && bet_ready` on an edge.
- `num`  out  4  digit to the core; 0 outside SEND.
- `insere`  out  1  digit-valid strobe to the core.
- `fim`  out  1  one-cycle end-of-entry pulse.
- `fim_jogo`  out  1  one-cycle end-of-round pulse.
- `premio_in`  in  2  prize code from the core (0, 1 or 2).
- `result`  out  2  captured prize for the last completed bet.
- `result_valid`  out  1  one-cycle pulse when `result` updates.
- `err`  out  1  one-cycle pulse: the last accepted bet had a nibble > 9.
- `busy`  out  1  FSM not in IDLE.
- `count`  out  $clog2(DEPTH)+1  bets queued.

## Operation
- Reset values: `num`=0, `insere`=`fim`=`fim_jogo`=0, `result`=0, `result_valid`=0, `err`=0, `busy`=0, `count`=0, `bet_ready`=1. FSM is in IDLE and the FIFO is flushed.
- `bet_ready` = (`count` < DEPTH). It is combinational from `count` and is never asserted when full, even if a dequeue happens on the same edge.
- BCD check at accept:
  - If any nibble > 9, the transfer still completes but the bet is discarded.
  - `count` does not change, and `err` pulses in the next cycle.
- FIFO is circular: pointer wrap-around modulo DEPTH. An enqueue and a dequeue on the same edge leave `count` unchanged.
- FSM states:
  - IDLE: `busy`=0. If `count`≠0, dequeue the head into a shift register, set the digit counter to 0 and go to SEND.
  - SEND: `insere`=1 and `num`=current digit, for DIGITS cycles, one digit per cycle, MSB nibble first. Then go to GAP.
  - GAP: all strobes 0, `num`=0, for GAP cycles. Then go to FIM.
  - FIM: `fim`=1 for one cycle. Then go to FJOG.
  - FJOG: `fim_jogo`=1 for one cycle. `premio_in` is registered into `result` on the edge that leaves FJOG. Then go to SETTLE.
  - SETTLE: all strobes 0 and `result_valid`=1 for one cycle. Then go to IDLE.
- All core-facing outputs are registered and decoded from state, so they carry no combinational path from inputs.
- `premio_in` = 3 is stored unchanged. Range checking belongs to the host.

## Timing
- A bet accepted at edge E0 gives `count`=1 after E0. The FSM leaves IDLE at E1, and `insere` is high in the DIGITS cycles following E1.
- One bet occupies 1 (IDLE) + DIGITS + GAP + 3 cycles. With the defaults that is 10 cycles, the same spacing the lottery core is verified with.
- Back-to-back bets with a non-empty FIFO start `insere` exactly every DIGITS+GAP+4 cycles.
- `result_valid` is high in the cycle after the `fim_jogo` cycle.
- `err` is high in the cycle after the accepting edge. It never coincides with a state change caused by that bet.
- Reset low in any state, including mid-SEND: on that edge all outputs go to reset values and the partial bet is dropped. No `fim` and no `result_valid` follow.
- `bet_valid` held high during reset is not accepted on the reset edge.

## Test plan
- Single bet 0x47010, `premio_in`=1:
  - `num` = 4,7,0,1,0 with `insere`=1 over 5 consecutive cycles.
  - 1 low cycle, then `fim` for 1 cycle, then `fim_jogo` for 1 cycle.
  - `result`=1 with `result_valid` in the next cycle.
- Three bets 0x67039, 0x47029, 0x23119 offered on consecutive edges:
  - `insere` rising edges are 10 cycles apart.
  - `premio_in` = 2, 1, 0 in the respective FJOG cycles gives `result` = 2, 1, 0.
  - `count` peaks at 3 and returns to 0.
- Five bets with `bet_valid` held high while the FSM is busy:
  - `count` reaches 4 and `bet_ready`=0.
  - The 5th bet stalls until the first dequeue, then is accepted and transmitted in order after the other four.
- Bet 0x4A019:
  - `err`=1 for 1 cycle and `count` stays 0.
  - No `insere`; a following valid bet 0x17011 transmits normally.
- Reset taken low during the 3rd SEND cycle with 2 bets queued:
  - Next cycle: all outputs 0, `count`=0, `bet_ready`=1.
  - No `fim` or `result_valid` appears within 20 cycles.
